// File: rtl/conv_pkg.sv
// Shared constants and helpers for the K=3, rate-1/2 convolutional code
// (G0=111, G1=101). The branch metric and trellis blocks import this package too.
package conv_pkg;

    localparam int         K  = 3;
    localparam logic [2:0] G0 = 3'b111;
    localparam logic [2:0] G1 = 3'b101;

    // Bit positions inside a radix-4 code word {c0_first, c1_first, c0_second, c1_second}
    localparam int CW_C0_FIRST  = 3;
    localparam int CW_C1_FIRST  = 2;
    localparam int CW_C0_SECOND = 1;
    localparam int CW_C1_SECOND = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } enc_state_e;

    // {c0, c1} for input bit u with encoder state {a, b}
    function automatic logic [1:0] branch_bits(input logic u, input logic [1:0] st);
        logic [K-1:0] taps;
        taps = {u, st};
        return {^(taps & G0), ^(taps & G1)};
    endfunction

endpackage

// File: rtl/conv_encoder_r4_if.sv
// Stream interface of the radix-4 encoder: pair input, code-word output, frame control.
interface conv_encoder_r4_if;
    logic       i_start;
    logic       i_valid;
    logic [1:0] i_data;
    logic       o_ready;
    logic [3:0] o_code;
    logic       o_valid;
    logic       i_ready;
    logic       o_last;
    logic       o_busy;

    modport slave (
        input  i_start, i_valid, i_data, i_ready,
        output o_ready, o_code, o_valid, o_last, o_busy
    );

    modport master (
        output i_start, i_valid, i_data, i_ready,
        input  o_ready, o_code, o_valid, o_last, o_busy
    );
endinterface

// File: rtl/conv_r4_step.sv
// Two trellis steps in one: encodes pair_i[1] then pair_i[0] starting from state_i.
module conv_r4_step
    import conv_pkg::*;
(
    input  logic [1:0] pair_i,
    input  logic [1:0] state_i,
    output logic [3:0] code_o,
    output logic [1:0] next_state_o
);

    logic [1:0] c_first;
    logic [1:0] c_second;
    logic [1:0] mid_state;

    always_comb begin
        c_first      = branch_bits(pair_i[1], state_i);
        mid_state    = {pair_i[1], state_i[1]};
        c_second     = branch_bits(pair_i[0], mid_state);
        next_state_o = {pair_i[0], mid_state[1]};

        code_o               = '0;
        code_o[CW_C0_FIRST]  = c_first[1];
        code_o[CW_C1_FIRST]  = c_first[0];
        code_o[CW_C0_SECOND] = c_second[1];
        code_o[CW_C1_SECOND] = c_second[0];
    end

endmodule

// File: rtl/conv_encoder_r4.sv
// Radix-4 framed convolutional encoder: FRAME_LEN data words followed by one
// zero-pair tail word that drives the trellis back to state 0.
module conv_encoder_r4
    import conv_pkg::*;
#(
    parameter  int FRAME_LEN = 8,
    localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    conv_encoder_r4_if.slave   bus
);

    enc_state_e       fsm_q, fsm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       enc_q, enc_d;
    logic [3:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;

    logic             slot_free;
    logic             ready;
    logic [1:0]       step_pair;
    logic [3:0]       step_code;
    logic [1:0]       step_next;

    // The tail reuses the same step logic with the pair forced to zero
    assign step_pair = (fsm_q == DATA) ? bus.i_data : 2'b00;

    conv_r4_step u_step (
        .pair_i       (step_pair),
        .state_i      (enc_q),
        .code_o       (step_code),
        .next_state_o (step_next)
    );

    assign slot_free = !valid_q || bus.i_ready;
    assign ready     = (fsm_q == DATA) && slot_free;

    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        enc_d   = enc_q;
        code_d  = code_q;
        valid_d = valid_q;
        last_d  = last_q;

        if (valid_q && bus.i_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        unique case (fsm_q)
            IDLE: begin
                enc_d = 2'b00;
                cnt_d = '0;
                if (bus.i_start) begin
                    fsm_d = DATA;
                end
            end
            DATA: begin
                if (bus.i_valid && ready) begin
                    code_d  = step_code;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    enc_d   = step_next;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                        fsm_d = TAIL;
                    end
                end
            end
            TAIL: begin
                // Return to IDLE without waiting for the tail word to drain
                if (slot_free) begin
                    code_d  = step_code;
                    valid_d = 1'b1;
                    last_d  = 1'b1;
                    enc_d   = 2'b00;
                    fsm_d   = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q   <= IDLE;
            cnt_q   <= '0;
            enc_q   <= 2'b00;
            code_q  <= 4'b0000;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            enc_q   <= enc_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign bus.o_ready = ready;
    assign bus.o_code  = code_q;
    assign bus.o_valid = valid_q;
    assign bus.o_last  = last_q;
    assign bus.o_busy  = (fsm_q != IDLE);

endmodule

// File: tb/tb_conv_encoder_r4.sv
// Directed bench for conv_encoder_r4: one-pair frames with hand-computed words,
// an eight-pair frame with stalls against a small reference model, and mid-frame reset.
module tb_conv_encoder_r4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    conv_encoder_r4_if bus1 ();
    conv_encoder_r4_if bus8 ();

    conv_encoder_r4 #(.FRAME_LEN(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    conv_encoder_r4 #(.FRAME_LEN(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {code[3:0], next_state[1:0]}; earlier bit is p[1]
    function automatic logic [5:0] ref_pair(input logic [1:0] p, input logic [1:0] s);
        logic [3:0] w;
        logic [1:0] st;
        logic       u;
        w  = 4'b0000;
        st = s;
        for (int k = 1; k >= 0; k--) begin
            u  = p[k];
            w  = {w[1:0], u ^ st[1] ^ st[0], u ^ st[0]};
            st = {u, st[1]};
        end
        return {w, st};
    endfunction

    logic [1:0] pairs [8] = '{2'b11, 2'b01, 2'b10, 2'b00, 2'b11, 2'b10, 2'b01, 2'b11};
    logic [4:0] exp_q [$];
    logic [1:0] mstate;
    logic [5:0] r;
    int         acc;
    int         words;
    logic       tail_pulsed;
    logic       stall;
    logic       tail_hold;

    initial begin
        bus1.i_start = 1'b0; bus1.i_valid = 1'b0; bus1.i_data = 2'b00; bus1.i_ready = 1'b1;
        bus8.i_start = 1'b0; bus8.i_valid = 1'b0; bus8.i_data = 2'b00; bus8.i_ready = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_code",  {4'b0, bus8.o_code}, 8'h00);
        chk("rst_valid", bus8.o_valid, 1'b0);
        chk("rst_last",  bus8.o_last,  1'b0);
        chk("rst_ready", bus8.o_ready, 1'b0);
        chk("rst_busy",  bus8.o_busy,  1'b0);
        chk("rst_busy1", bus1.o_busy,  1'b0);
        @(negedge clk);
        rst = 1'b1;

        // FRAME_LEN=1, pair 11; start together with valid must not accept
        @(negedge clk);
        bus1.i_start = 1'b1; bus1.i_valid = 1'b1; bus1.i_data = 2'b11;
        #1 chk("a_idle_ready", bus1.o_ready, 1'b0);
        @(negedge clk);
        bus1.i_start = 1'b0;
        #1;
        chk("a_start_no_accept", bus1.o_valid, 1'b0);
        chk("a_busy", bus1.o_busy, 1'b1);
        chk("a_data_ready", bus1.o_ready, 1'b1);
        @(negedge clk);
        bus1.i_valid = 1'b0;
        #1;
        chk("a_code_11", {4'b0, bus1.o_code}, 8'h0D);
        chk("a_valid", bus1.o_valid, 1'b1);
        chk("a_last0", bus1.o_last, 1'b0);
        chk("a_tail_ready", bus1.o_ready, 1'b0);
        // Tail loads; hold it and restart while it is still held
        @(negedge clk);
        bus1.i_ready = 1'b0; bus1.i_start = 1'b1;
        #1;
        chk("a_tail_code", {4'b0, bus1.o_code}, 8'h07);
        chk("a_tail_last", bus1.o_last, 1'b1);
        chk("a_tail_valid", bus1.o_valid, 1'b1);
        chk("a_idle_busy", bus1.o_busy, 1'b0);
        @(negedge clk);
        bus1.i_start = 1'b0;
        #1;
        chk("a_tail_hold_code", {4'b0, bus1.o_code}, 8'h07);
        chk("a_tail_hold_last", bus1.o_last, 1'b1);
        chk("a_restart_busy", bus1.o_busy, 1'b1);
        chk("a_hold_ready", bus1.o_ready, 1'b0);
        bus1.i_ready = 1'b1;
        #1 chk("a_comb_ready", bus1.o_ready, 1'b1);
        @(negedge clk);
        #1 chk("a_drained", bus1.o_valid, 1'b0);
        // Second frame, pair 10
        bus1.i_valid = 1'b1; bus1.i_data = 2'b10;
        @(negedge clk);
        bus1.i_valid = 1'b0;
        #1;
        chk("a_code_10", {4'b0, bus1.o_code}, 8'h0E);
        chk("a_last_10", bus1.o_last, 1'b0);
        @(negedge clk);
        #1;
        chk("a_tail_10", {4'b0, bus1.o_code}, 8'h0C);
        chk("a_tail_10_last", bus1.o_last, 1'b1);
        chk("a_tail_10_busy", bus1.o_busy, 1'b0);

        // FRAME_LEN=8 with a 3-cycle stall and stray start pulses
        mstate = 2'b00; acc = 0; words = 0; tail_pulsed = 1'b0;
        for (int cyc = 0; cyc < 60 && words < 9; cyc++) begin
            @(negedge clk);
            stall        = (cyc >= 4 && cyc <= 6);
            tail_hold    = (acc == 8) && !tail_pulsed;
            bus8.i_ready = !(stall || tail_hold);
            bus8.i_valid = (acc < 8);
            bus8.i_data  = (acc < 8) ? pairs[acc] : 2'b00;
            bus8.i_start = (cyc == 0) || (cyc == 2) || tail_hold;
            #1;
            if (tail_hold) begin
                tail_pulsed = 1'b1;
                chk("b_tail_busy", bus8.o_busy, 1'b1);
                chk("b_tail_ready", bus8.o_ready, 1'b0);
            end
            if (stall && bus8.o_valid) chk("b_stall_ready", bus8.o_ready, 1'b0);
            if (bus8.o_valid) begin
                if (exp_q.size() == 0) begin
                    chk("b_unexpected_word", bus8.o_valid, 1'b0);
                end else begin
                    chk("b_code", {4'b0, bus8.o_code}, {4'b0, exp_q[0][4:1]});
                    chk("b_last", bus8.o_last, exp_q[0][0]);
                    if (bus8.i_ready) begin
                        void'(exp_q.pop_front());
                        words++;
                    end
                end
            end
            if (bus8.o_ready && bus8.i_valid) begin
                r = ref_pair(pairs[acc], mstate);
                exp_q.push_back({r[5:2], 1'b0});
                mstate = r[1:0];
                acc++;
                if (acc == 8) begin
                    r = ref_pair(2'b00, mstate);
                    exp_q.push_back({r[5:2], 1'b1});
                    mstate = 2'b00;
                end
            end
        end
        chk("b_words", 8'(words), 8'd9);
        chk("b_queue_empty", 8'(exp_q.size()), 8'd0);
        bus8.i_start = 1'b0; bus8.i_ready = 1'b1; bus8.i_valid = 1'b1; bus8.i_data = 2'b11;
        @(negedge clk);
        #1;
        chk("b_end_busy", bus8.o_busy, 1'b0);
        chk("b_end_ready", bus8.o_ready, 1'b0);
        @(negedge clk);
        #1 chk("b_idle_ignores_valid", bus8.o_valid, 1'b0);

        // Reset in the middle of a frame
        bus8.i_valid = 1'b0;
        @(negedge clk);
        bus8.i_start = 1'b1;
        @(negedge clk);
        bus8.i_start = 1'b0; bus8.i_valid = 1'b1; bus8.i_data = 2'b11;
        @(negedge clk);
        @(negedge clk);
        bus8.i_valid = 1'b0;
        #1 chk("c_pre_valid", bus8.o_valid, 1'b1);
        rst = 1'b0;
        #1;
        chk("c_rst_code",  {4'b0, bus8.o_code}, 8'h00);
        chk("c_rst_valid", bus8.o_valid, 1'b0);
        chk("c_rst_last",  bus8.o_last,  1'b0);
        chk("c_rst_ready", bus8.o_ready, 1'b0);
        chk("c_rst_busy",  bus8.o_busy,  1'b0);
        @(negedge clk);
        rst = 1'b1;
        bus8.i_start = 1'b1;
        @(negedge clk);
        bus8.i_start = 1'b0; bus8.i_valid = 1'b1; bus8.i_data = 2'b11;
        @(negedge clk);
        bus8.i_valid = 1'b0;
        #1;
        chk("c_fresh_code", {4'b0, bus8.o_code}, 8'h0D);
        chk("c_fresh_valid", bus8.o_valid, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/conv_encoder_r4.md
# conv_encoder_r4

Radix-4 convolutional encoder: rate 1/2, constraint length K=3, generators G0=111 and G1=101. Consumes two information bits per cycle and emits one 4-bit code word per cycle, so one output word matches one branch-metric input symbol at the Viterbi decoder. Runs fixed-length frames and appends one zero tail pair so the decoder's trellis terminates in state 0. Sits at the transmit end of the decoder test chain and feeds the channel model and branch metric unit.

## Interface
- FRAME_LEN, 8: information bit pairs per frame; must be ≥1.
- CNT_W, $clog2(FRAME_LEN+1): width of the pair counter; derived, not overridden.

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_start  in  1  frame start pulse; honoured only in IDLE.
- i_valid  in  1  input pair valid.
- i_data  in  2  input pair; i_data[1] is the earlier bit in time.
- o_ready  out  1  encoder accepts i_data this cycle.
- o_code  out  4  code word {c0_first, c1_first, c0_second, c1_second}.
- o_valid  out  1  o_code valid.
- i_ready  in  1  downstream accepts o_code this cycle.
- o_last  out  1  qualifies the tail word (last word of frame).
- o_busy  out  1  high in any state other than IDLE.

## Operation
- Encoder state {a,b}: a is the previous bit, b the bit before it. Per bit u: c0=u^a^b, c1=u^b; next state {u,a}.
- Per pair, apply the rule to i_data[1], then to i_data[0] from the intermediate state.
- FSM states: IDLE, DATA, TAIL.
  - IDLE: o_ready=0, encoder state forced to 00, pair counter=0. i_start=1 → DATA. i_valid is ignored.
  - DATA: accept when i_valid && o_ready. Then encode, load the output register, update the state, and increment the counter. If an accept happens while counter==FRAME_LEN-1 → TAIL.
  - TAIL: o_ready=0. When the output slot is free, load the code for pair 00, set o_last=1, clear the encoder state, and go to IDLE.
- Output slot is free when !o_valid || i_ready.
- o_ready = (state==DATA) && slot free.
- o_valid clears on a handshake unless a new word loads in the same cycle.
- o_code, o_valid and o_last hold stable while o_valid && !i_ready.
- i_start outside IDLE is ignored.
- i_start and i_valid in the same IDLE cycle: only the transition happens. Data is accepted from the next cycle on.
- Frame end: the transition to IDLE does not wait for the tail word to drain. A new i_start may arrive while the tail word is still held. The tail word is kept until it is accepted.
- Reset mid-frame: every register clears asynchronously and the FSM returns to IDLE. The partial frame is discarded and no tail word is emitted.
- Reset values: o_code=0, o_valid=0, o_last=0, o_ready=0, o_busy=0; FSM=IDLE, counter=0, encoder state=00.

## Timing
- Latency: a pair accepted at edge N appears on o_code with o_valid=1 after edge N, one cycle later.
- Throughput: one pair per cycle while i_ready=1.
- i_ready=0 stalls input through o_ready in the same cycle. This is a combinational path from i_ready to o_ready.
- IDLE→DATA takes one edge after i_start.
- The tail word loads at the first edge in TAIL where the slot is free.
- Frame length in output words is FRAME_LEN+1. The minimum frame takes 1+FRAME_LEN+1 cycles from i_start to the tail word being valid, with no stalls.

## Structure
- Shared package conv_pkg holds:
  - K=3, G0=3'b111, G1=3'b101;
  - the FSM state enum (IDLE/DATA/TAIL);
  - the code-word bit-order constants.
- The branch metric unit and the future trellis/ACS blocks reuse this package.
- Sub-module conv_r4_step is purely combinational: (pair[1:0], state[1:0]) → (code[3:0], next_state[1:0]). It is instantiated once for data and reused for the tail with the pair forced to 00.

## Test plan
- Reset, then i_start, then i_data=2'b11 from state 00 with i_ready=1 → o_code=4'b1101 after one cycle; state becomes 11.
- FRAME_LEN=1, i_data=2'b11 → words 1101, then tail 0111 with o_last=1; o_busy drops after the tail is loaded.
- FRAME_LEN=1, i_data=2'b10 → words 1110, then tail 1100 with o_last=1.
- i_ready held at 0 for 3 cycles mid-frame → o_code and o_valid hold, o_ready=0, no pair is lost or duplicated. Compare against a reference model over FRAME_LEN=8 random pairs.
- Assert rst low while in DATA with o_valid=1 → all outputs are 0 immediately. The next frame encodes from state 00.
- i_start pulsed during DATA and during TAIL → ignored, frame length unchanged. i_start together with i_valid in IDLE → that pair is not accepted.
